alu32_issue_stage: RTL and testbench
====================================

Name: alu32_issue_stage

Overview:
- Front-end stage that feeds the 32-bit ALU (alu32) and consumes its result.
- Accepts operation requests (A, B, control) over a valid/ready handshake and buffers them in a small FIFO.
- Issues one operation at a time onto registered ALU operand ports, then captures the ALU output and flags into a result register with a valid/ready handshake.
- Also keeps a sticky overflow flag and a completed-operation counter for status reads.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- CNT_W, 16, width of op_count.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- req_valid  in  1  request present
- req_ready  out  1  stage can accept a request
- req_A  in  32  operand A
- req_B  in  32  operand B
- req_control  in  3  ALU opcode (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_NOR`, `ALU_XOR` encodings)
- alu_A  out  32  registered operand A to alu32
- alu_B  out  32  registered operand B to alu32
- alu_control  out  3  registered opcode to alu32
- alu_out  in  32  alu32 result (combinational from alu_A/alu_B/alu_control)
- alu_overflow  in  1  alu32 overflow flag
- alu_zero  in  1  alu32 zero flag
- alu_negative  in  1  alu32 negative flag
- res_valid  out  1  result register holds an unconsumed result
- res_ready  in  1  consumer accepts the result
- res_data  out  32  captured result
- res_overflow  out  1  captured overflow flag
- res_zero  out  1  captured zero flag
- res_negative  out  1  captured negative flag
- sticky_overflow  out  1  set by any captured overflow; held until cleared
- clear_sticky  in  1  synchronous clear of sticky_overflow
- op_count  out  CNT_W  count of completed result handshakes

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO empty, so req_ready=1.
  - State IDLE.
  - alu_A, alu_B, alu_control, res_data, all res_* flags, res_valid, sticky_overflow and op_count are all 0.
  - In-flight and buffered operations are discarded.
- FIFO push: occurs on a clock edge when req_valid & req_ready. req_ready = !full. There is no bypass, so a push into an empty FIFO is poppable at the earliest on the next edge.
- FSM IDLE:
  - If FIFO non-empty at the edge, pop the head into alu_A/alu_B/alu_control and go to EXEC.
  - Otherwise stay in IDLE; operand registers hold their last value.
- FSM EXEC (exactly one cycle):
  - At the edge, capture alu_out and the three flags into the res_* registers and set res_valid=1.
  - If alu_overflow=1, set sticky_overflow.
  - Go to WAIT.
- FSM WAIT:
  - res_data and res_* flags are held stable while res_valid & !res_ready.
  - On an edge with res_ready=1: clear res_valid and increment op_count.
  - On that same edge, if the FIFO is non-empty, pop the next head into the operand registers and go to EXEC; otherwise go to IDLE.
- Latency: a request accepted at edge E0 into an empty, idle stage is issued at E1 and captured at E2. res_valid is high after E2. Peak throughput is one operation per 2 cycles.
- Ordering: results are produced strictly in request order; no operation is dropped or duplicated.
- Simultaneous push and pop on one edge: both take effect; the occupancy count is unchanged.
- Full FIFO: req_ready=0. A request held with req_valid=1 is accepted on the first edge after a pop frees an entry.
- Sticky overflow: clear_sticky=1 clears it. If a capture with overflow and clear_sticky occur on the same edge, set wins.
- op_count wraps from all-ones to 0 without saturating.
- The opcode is passed through unchanged. Flag semantics are alu32's; this stage neither interprets nor checks them.

Test Plan:
- Single op: req A=8, B=4, `ALU_ADD`, res_ready=1 -> res_valid rises 2 edges after acceptance; res_data=12, overflow/zero/negative=0; op_count=1.
- Back-to-back sequence: 2-5 `ALU_SUB`, 3&7 `ALU_AND`, 6-6 `ALU_SUB` -> results in order: 32'hFFFFFFFD (negative=1), 3, 0 (zero=1); results spaced exactly 2 cycles apart.
- Overflow and sticky: 32'h7FFFFFFF + 32'h7FFFFFFF `ALU_ADD` -> res_data=32'hFFFFFFFE, res_overflow=1, sticky_overflow=1.
  - Then 1+1 -> sticky stays 1.
  - Pulse clear_sticky -> sticky 0.
  - Repeat the overflow with clear_sticky asserted on the capture edge -> sticky 1.
- Backpressure/full: hold res_ready=0 and push 6 requests -> one result is held stable and 4 requests are buffered; req_ready=0 is seen while FIFO full.
  - Then release res_ready=1 -> all 6 results emerge in order; op_count=6.
- Reset mid-operation: assert reset in EXEC with 3 requests buffered -> outputs immediately return to reset values; after release, no stale result appears and a new request completes normally.
- Counter wrap: preload or run op_count to 16'hFFFF, complete one more op -> op_count=0.

Source files
------------

// File: rtl/alu32_issue_stage.sv
// Issue stage in front of alu32: buffers requests in a small FIFO, issues one
// operation at a time on registered operand ports and captures the result.
module alu32_issue_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_A,
    input  logic [31:0]      req_B,
    input  logic [2:0]       req_control,
    output logic [31:0]      alu_A,
    output logic [31:0]      alu_B,
    output logic [2:0]       alu_control,
    input  logic [31:0]      alu_out,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    input  logic             alu_negative,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_overflow,
    output logic             res_zero,
    output logic             res_negative,
    output logic             sticky_overflow,
    input  logic             clear_sticky,
    output logic [CNT_W-1:0] op_count
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
    } req_t;

    req_t             fifo_mem [DEPTH];
    req_t             head;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             fifo_empty, fifo_full, push, pop;

    logic [1:0]       state_q, state_d;
    logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]       alu_ctl_q, alu_ctl_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic             res_ovf_q, res_ovf_d, res_zero_q, res_zero_d, res_neg_q, res_neg_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    assign head       = fifo_mem[rd_ptr_q];

    // Storage carries no reset: emptiness is defined purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{a: req_A, b: req_B, ctl: req_control};
        end
    end

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctl_d   = alu_ctl_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;
        res_zero_d  = res_zero_q;
        res_neg_d   = res_neg_q;
        sticky_d    = sticky_q;
        op_count_d  = op_count_q;
        pop         = 1'b0;

        if (clear_sticky) begin
            sticky_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_valid_d = 1'b1;
                res_data_d  = alu_out;
                res_ovf_d   = alu_overflow;
                res_zero_d  = alu_zero;
                res_neg_d   = alu_negative;
                // Overriding the clear above makes a coincident overflow win.
                if (alu_overflow) begin
                    sticky_d = 1'b1;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            alu_a_d   = head.a;
            alu_b_d   = head.b;
            alu_ctl_d = head.ctl;
        end
    end

    assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctl_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
            res_zero_q  <= 1'b0;
            res_neg_q   <= 1'b0;
            sticky_q    <= 1'b0;
            op_count_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctl_q   <= alu_ctl_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
            res_zero_q  <= res_zero_d;
            res_neg_q   <= res_neg_d;
            sticky_q    <= sticky_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_A           = alu_a_q;
    assign alu_B           = alu_b_q;
    assign alu_control     = alu_ctl_q;
    assign res_valid       = res_valid_q;
    assign res_data        = res_data_q;
    assign res_overflow    = res_ovf_q;
    assign res_zero        = res_zero_q;
    assign res_negative    = res_neg_q;
    assign sticky_overflow = sticky_q;
    assign op_count        = op_count_q;
endmodule

// File: tb/tb_alu32_issue_stage.sv
// Bench for alu32_issue_stage: models alu32 behind the stage, scoreboards every
// result handshake against a request-order queue and runs directed corner sequences.
module tb_alu32_issue_stage;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] d;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready;
    logic [31:0]      req_A, req_B;
    logic [2:0]       req_control;
    logic [31:0]      alu_A, alu_B, alu_out;
    logic [2:0]       alu_control;
    logic             alu_overflow, alu_zero, alu_negative;
    logic             res_valid, res_ready;
    logic [31:0]      res_data;
    logic             res_overflow, res_zero, res_negative;
    logic             sticky_overflow, clear_sticky;
    logic [CNT_W-1:0] op_count;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    res_t             exp_q[$];
    int               hs_cyc[$];
    logic [CNT_W-1:0] model_cnt;
    logic             held_valid = 1'b0;
    res_t             held;
    logic             rand_rr = 1'b0;
    res_t             alu_r;
    vec_t             vecs [10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu32_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_control(req_control),
        .alu_A(alu_A), .alu_B(alu_B), .alu_control(alu_control),
        .alu_out(alu_out), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_negative(alu_negative),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_overflow(res_overflow), .res_zero(res_zero), .res_negative(res_negative),
        .sticky_overflow(sticky_overflow), .clear_sticky(clear_sticky),
        .op_count(op_count)
    );

    // Arithmetic reference for alu32: signed overflow judged in 64-bit space.
    function automatic res_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] op);
        res_t  r;
        longint sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sr = 0;
        r.ovf = 1'b0;
        case (op)
            ALU_ADD: begin sr = sa + sb; r.data = a + b; r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
            ALU_SUB: begin sr = sa - sb; r.data = a - b; r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
            ALU_AND: r.data = a & b;
            ALU_OR:  r.data = a | b;
            ALU_XOR: r.data = a ^ b;
            ALU_NOR: r.data = ~(a | b);
            default: r.data = 32'd0;
        endcase
        r.zero = (r.data == 32'd0);
        r.neg  = r.data[31];
        return r;
    endfunction

    always_comb alu_r = ref_alu(alu_A, alu_B, alu_control);
    assign alu_out      = alu_r.data;
    assign alu_overflow = alu_r.ovf;
    assign alu_zero     = alu_r.zero;
    assign alu_negative = alu_r.neg;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every accepted request must come back once, in order.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            model_cnt  = '0;
            held_valid = 1'b0;
        end else begin
            if (held_valid && res_valid)
                check("res_hold_stable", 64'({res_data, res_overflow, res_zero, res_negative}), 64'(held));
            if (res_valid && res_ready) begin
                check("op_count", 64'(op_count), 64'(model_cnt));
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_result: got %0h expected none (cycle %0d)", res_data, cyc);
                end else begin
                    check("res_in_order", 64'({res_data, res_overflow, res_zero, res_negative}),
                          64'(exp_q.pop_front()));
                end
                $display("result data=%08h ovf=%0d zero=%0d neg=%0d count=%0d",
                         res_data, res_overflow, res_zero, res_negative, op_count);
                model_cnt = model_cnt + 1'b1;
                hs_cyc.push_back(cyc);
            end
            held_valid = res_valid && !res_ready;
            held       = '{res_data, res_overflow, res_zero, res_negative};
            if (req_valid && req_ready)
                exp_q.push_back(ref_alu(req_A, req_B, req_control));
        end
    end

    always @(posedge clk) begin
        if (rand_rr) begin
            #1;
            res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    // Presents a request at posedge+1 and returns one tick after it is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        int n = 0;
        req_valid = 1'b1; req_A = a; req_B = b; req_control = op;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 500) begin
            mismatched++;
            $display("FAIL send_timeout: got req_ready=0 expected 1 within 500 cycles");
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || res_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 3000) begin
            mismatched++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        tick();
    endtask

    logic [2:0]  ops [6];
    logic [31:0] corner [4];

    initial begin
        ops    = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR};
        corner = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[0] = '{32'd8,        32'd4,        ALU_ADD, 32'd12,       1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd2,        32'd5,        ALU_SUB, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'd3,        32'd7,        ALU_AND, 32'd3,        1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'd6,        32'd6,        ALU_SUB, 32'd0,        1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, ALU_ADD, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'hF0,       32'h0F,       ALU_OR,  32'hFF,       1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'd0,        32'd0,        ALU_NOR, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'd5,        32'd5,        ALU_XOR, 32'd0,        1'b0, 1'b1, 1'b0};
        vecs[8] = '{32'h80000000, 32'd1,        ALU_SUB, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{32'hFFFFFFFF, 32'd1,        ALU_ADD, 32'd0,        1'b0, 1'b1, 1'b0};

        reset = 1'b0; req_valid = 1'b0; req_A = '0; req_B = '0; req_control = '0;
        res_ready = 1'b0; clear_sticky = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_alu_regs", 64'({alu_A, alu_control}), 64'd0);
        check("rst_res_regs", 64'({res_data, res_overflow, res_zero, res_negative}), 64'd0);
        check("rst_sticky", 64'(sticky_overflow), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Latency: accepted at E0, issued at E1, captured at E2.
        res_ready = 1'b1;
        send(32'd8, 32'd4, ALU_ADD);
        check("lat_e0_valid", 64'(res_valid), 64'd0);
        tick();
        check("lat_e1_issue", 64'({alu_A, alu_B, alu_control}), 64'({32'd8, 32'd4, ALU_ADD}));
        check("lat_e1_valid", 64'(res_valid), 64'd0);
        tick();
        check("lat_e2_valid", 64'(res_valid), 64'd1);
        check("lat_e2_result", 64'({res_data, res_overflow, res_zero, res_negative}), 64'({32'd12, 3'b000}));
        tick();
        check("lat_e3_count", 64'(op_count), 64'd1);
        check("lat_e3_valid", 64'(res_valid), 64'd0);

        // Back-to-back requests must emerge exactly 2 cycles apart.
        hs_cyc.delete();
        send(32'd2, 32'd5, ALU_SUB);
        send(32'd3, 32'd7, ALU_AND);
        send(32'd6, 32'd6, ALU_SUB);
        drain();
        check("b2b_count", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3) begin
            check("b2b_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd2);
            check("b2b_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd2);
        end

        // Table-driven vectors, each checked directly against its own record.
        for (int i = 0; i < 10; i++) begin
            int n = 0;
            send(vecs[i].a, vecs[i].b, vecs[i].op);
            @(negedge clk);
            while (!res_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("vec%0d_result", i),
                  64'({res_valid, res_data, res_overflow, res_zero, res_negative}),
                  64'({1'b1, vecs[i].d, vecs[i].ovf, vecs[i].zero, vecs[i].neg}));
            drain();
        end

        // Sticky overflow set / hold / clear / set-beats-clear.
        do_reset();
        res_ready = 1'b1;
        check("sticky_after_rst", 64'(sticky_overflow), 64'd0);
        send(32'h7FFFFFFF, 32'h7FFFFFFF, ALU_ADD);
        drain();
        check("sticky_set", 64'(sticky_overflow), 64'd1);
        send(32'd1, 32'd1, ALU_ADD);
        drain();
        check("sticky_hold", 64'(sticky_overflow), 64'd1);
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        check("sticky_clear", 64'(sticky_overflow), 64'd0);
        res_ready = 1'b0;
        send(32'h7FFFFFFF, 32'h7FFFFFFF, ALU_ADD);
        clear_sticky = 1'b1;
        tick();
        tick();
        clear_sticky = 1'b0;
        check("sticky_set_wins", 64'({sticky_overflow, res_valid, res_overflow}), 64'(3'b111));
        res_ready = 1'b1;
        drain();

        // Backpressure: one result held, four buffered, sixth request stalls.
        do_reset();
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(32'(i), 32'd100, ALU_ADD);
        req_valid = 1'b1; req_A = 32'd6; req_B = 32'd100; req_control = ALU_ADD;
        repeat (3) begin
            @(negedge clk);
            check("full_req_ready", 64'(req_ready), 64'd0);
        end
        check("full_held_result", 64'({res_valid, res_data}), 64'({1'b1, 32'd101}));
        tick();
        res_ready = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("full_accept_after_pop", 64'(req_ready), 64'd1);
            tick();
            req_valid = 1'b0;
        end
        drain();
        check("full_op_count", 64'(op_count), 64'd6);

        // Reset while EXEC is active with three entries still buffered.
        do_reset();
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(32'(i * 3), 32'd1, ALU_SUB);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_outputs", 64'({res_valid, req_ready, res_data, alu_control}), 64'({2'b01, 32'd0, 3'd0}));
        check("midrst_alu_a", 64'(alu_A), 64'd0);
        check("midrst_op_count", 64'(op_count), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        res_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(res_valid), 64'd0);
        end
        tick();
        send(32'd9, 32'd3, ALU_SUB);
        drain();
        check("midrst_new_op_count", 64'(op_count), 64'd1);

        // Randomized traffic with random backpressure, checked by the scoreboard.
        rand_rr = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            send(a, b, ops[$urandom_range(0, 5)]);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        rand_rr = 1'b0;
        tick();
        res_ready = 1'b1;

        // Counter wrap at the bench's CNT_W.
        do_reset();
        for (int i = 0; i < (1 << CNT_W) - 1; i++) send($urandom, $urandom, ops[$urandom_range(0, 5)]);
        drain();
        check("wrap_all_ones", 64'(op_count), 64'((1 << CNT_W) - 1));
        send(32'd1, 32'd2, ALU_OR);
        drain();
        check("wrap_to_zero", 64'(op_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
